// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising 16-bit LFSR stream checker
//
// Locks a local copy of the generator LFSR onto the received word stream,
// then checks every following valid word against its prediction.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   in_valid      in_data carries one generator word this cycle
//   in_data       received LFSR word
//   clear_counts  synchronous clear of err_count and word_count
//   locked        checker is in LOCKED state
//   err_pulse     one-cycle flag: previous valid word mismatched while locked
//   err_count     mismatches while locked (saturating)
//   word_count    valid words checked while locked (saturating)
//   expected      predicted value of the next valid word
module lfsr_checker #(
   parameter logic [15:0] TAP_MASK   = 16'hB400,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned LOSS_COUNT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   input  logic        clear_counts,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_count,
   output logic [31:0] word_count,
   output logic [15:0] expected
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int MCW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
   localparam int LCW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
   localparam logic [MCW-1:0] LOCK_LAST = MCW'(LOCK_COUNT - 1);
   localparam logic [LCW-1:0] LOSS_LAST = LCW'(LOSS_COUNT - 1);

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & TAP_MASK)};
   endfunction

   state_t           state_q, state_d;
   logic [15:0]      expected_q, expected_d;
   logic [MCW-1:0]   match_cnt_q, match_cnt_d;
   logic [LCW-1:0]   miss_cnt_q, miss_cnt_d;
   logic             err_pulse_q, err_pulse_d;
   logic [15:0]      err_count_q, err_count_d;
   logic [31:0]      word_count_q, word_count_d;
   logic             locked_q, locked_d;

   logic             match;
   logic             data_zero;
   logic             err_inc;
   logic             word_inc;

   assign match     = (in_data == expected_q);
   assign data_zero = (in_data == 16'h0000);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (in_valid) begin
         case (state_q)
            HUNT: begin
               // all-zero word is the LFSR lock-up state and cannot seed
               if (!data_zero) state_d = VERIFY;
            end
            VERIFY: begin
               if (match) begin
                  if (match_cnt_q == LOCK_LAST) state_d = LOCKED;
               end else if (data_zero) begin
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               if (!match && (miss_cnt_q == LOSS_LAST)) state_d = HUNT;
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // Datapath and output logic
   always_comb begin
      expected_d  = expected_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_pulse_d = 1'b0;
      err_inc     = 1'b0;
      word_inc    = 1'b0;

      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (!data_zero) begin
                  expected_d  = lfsr_next(in_data);
                  match_cnt_d = '0;
               end
            end
            VERIFY: begin
               if (match) begin
                  expected_d = lfsr_next(expected_q);
                  if (match_cnt_q == LOCK_LAST) begin
                     match_cnt_d = '0;
                     miss_cnt_d  = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + 1'b1;
                  end
               end else begin
                  // reseed from the received word unless it is the lock-up value
                  match_cnt_d = '0;
                  if (!data_zero) expected_d = lfsr_next(in_data);
               end
            end
            LOCKED: begin
               // flywheel: prediction advances regardless of the received word
               expected_d = lfsr_next(expected_q);
               word_inc   = 1'b1;
               if (match) begin
                  miss_cnt_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  err_inc     = 1'b1;
                  miss_cnt_d  = (miss_cnt_q == LOSS_LAST) ? '0 : miss_cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (clear_counts) begin
         err_count_d  = '0;
         word_count_d = '0;
      end else begin
         err_count_d  = (err_inc && (err_count_q != 16'hFFFF)) ?
                        err_count_q + 16'd1 : err_count_q;
         word_count_d = (word_inc && (word_count_q != 32'hFFFF_FFFF)) ?
                        word_count_q + 32'd1 : word_count_q;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         expected_q   <= '0;
         match_cnt_q  <= '0;
         miss_cnt_q   <= '0;
         err_pulse_q  <= 1'b0;
         err_count_q  <= '0;
         word_count_q <= '0;
         locked_q     <= 1'b0;
      end else begin
         expected_q   <= expected_d;
         match_cnt_q  <= match_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         err_pulse_q  <= err_pulse_d;
         err_count_q  <= err_count_d;
         word_count_q <= word_count_d;
         locked_q     <= locked_d;
      end
   end

   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign err_count  = err_count_q;
   assign word_count = word_count_q;
   assign expected   = expected_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - self-checking bench for lfsr_checker
module tb_lfsr_checker;

   localparam int LOCK_COUNT = 4;
   localparam int LOSS_COUNT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_data;
   logic        clear_counts;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic [31:0] word_count;
   logic [15:0] expected;

   lfsr_checker #(
      .TAP_MASK   (16'hB400),
      .LOCK_COUNT (LOCK_COUNT),
      .LOSS_COUNT (LOSS_COUNT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .clear_counts (clear_counts),
      .locked       (locked),
      .err_pulse    (err_pulse),
      .err_count    (err_count),
      .word_count   (word_count),
      .expected     (expected)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int pulses = 0;
   int rise_idx, fall_idx;

   // reference model: 0 = hunting, 1 = verifying, 2 = locked
   int          m_mode;
   logic [15:0] m_exp;
   int          m_run;
   int          m_miss;
   logic [15:0] m_err;
   logic [31:0] m_words;
   bit          m_pulse;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & 16'hB400)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic model_step(input bit v, input logic [15:0] d, input bit clr, input bit rst);
      bit hit;
      if (rst) begin
         m_mode = 0; m_exp = '0; m_run = 0; m_miss = 0;
         m_err = '0; m_words = '0; m_pulse = 0;
         return;
      end
      m_pulse = 0;
      hit = (d == m_exp);
      if (v) begin
         if (m_mode == 0) begin
            if (d != 0) begin
               m_mode = 1; m_exp = lfsr_next(d); m_run = 0;
            end
         end else if (m_mode == 1) begin
            if (hit) begin
               m_run++;
               m_exp = lfsr_next(m_exp);
               if (m_run == LOCK_COUNT) begin
                  m_mode = 2; m_miss = 0;
               end
            end else if (d != 0) begin
               m_exp = lfsr_next(d); m_run = 0;
            end else begin
               m_mode = 0;
            end
         end else begin
            m_exp = lfsr_next(m_exp);
            if (m_words != 32'hFFFF_FFFF) m_words++;
            if (hit) begin
               m_miss = 0;
            end else begin
               m_pulse = 1;
               if (m_err != 16'hFFFF) m_err++;
               m_miss++;
               if (m_miss == LOSS_COUNT) m_mode = 0;
            end
         end
      end
      if (clr) begin
         m_err = '0; m_words = '0;
      end
   endtask

   task automatic compare_outputs();
      chk("locked",     32'(locked),     32'(m_mode == 2));
      chk("err_pulse",  32'(err_pulse),  32'(m_pulse));
      chk("err_count",  32'(err_count),  32'(m_err));
      chk("word_count", word_count,      m_words);
      chk("expected",   32'(expected),   32'(m_exp));
   endtask

   // one clock: drive at the falling edge, model after the rising edge, compare at the next falling edge
   task automatic cycle(input bit v, input logic [15:0] d, input bit clr, input bit rst);
      in_valid     = v;
      in_data      = d;
      clear_counts = clr;
      reset        = rst;
      @(posedge clk);
      model_step(v, d, clr, rst);
      @(negedge clk);
      compare_outputs();
      if (err_pulse === 1'b1) pulses++;
   endtask

   task automatic send_stream(input logic [15:0] seed, input int n, input int gap_pct, input int flip_idx);
      logic [15:0] g;
      logic [15:0] w;
      bit prev;
      int i;
      g = seed;
      i = 0;
      prev = locked;
      rise_idx = -1;
      fall_idx = -1;
      pulses = 0;
      while (i < n) begin
         if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            cycle(1'b0, 16'($urandom), 1'b0, 1'b0);
         end else begin
            w = g;
            if (i == flip_idx) w[0] = ~w[0];
            cycle(1'b1, w, 1'b0, 1'b0);
            if (locked && !prev && rise_idx < 0) rise_idx = i;
            if (!locked && prev && fall_idx < 0) fall_idx = i;
            prev = locked;
            g = lfsr_next(g);
            i++;
         end
      end
   endtask

   task automatic do_reset();
      cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] g;
      logic [15:0] w;
      bit v, clr, rst;
      int burst;

      model_step(1'b0, 16'h0000, 1'b0, 1'b1);

      // reset held with live random traffic
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
      chk("rst_locked",     32'(locked),     32'h0);
      chk("rst_err_pulse",  32'(err_pulse),  32'h0);
      chk("rst_err_count",  32'(err_count),  32'h0);
      chk("rst_word_count", word_count,      32'h0);
      chk("rst_expected",   32'(expected),   32'h0);

      // zero words are ignored while hunting; a seed then sets the prediction
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0000, 1'b0, 1'b0);
      chk("zero_hunt_expected", 32'(expected), 32'h0);
      chk("zero_hunt_locked",   32'(locked),   32'h0);
      cycle(1'b1, 16'h8000, 1'b0, 1'b0);
      chk("seed_8000_expected", 32'(expected), 32'h0001);
      cycle(1'b1, 16'h0001, 1'b0, 1'b0);
      chk("verify_0001_expected", 32'(expected), 32'h0002);

      // clean gapless lock
      do_reset();
      send_stream(16'h0001, 256, 0, -1);
      chk("clean_lock_idx",   32'(rise_idx),   32'd4);
      chk("clean_err_count",  32'(err_count),  32'd0);
      chk("clean_pulses",     32'(pulses),     32'd0);
      chk("clean_word_count", word_count,      32'd251);

      // gapped stream
      do_reset();
      send_stream(16'h0001, 256, 30, -1);
      chk("gap_lock_idx",   32'(rise_idx),   32'd4);
      chk("gap_err_count",  32'(err_count),  32'd0);
      chk("gap_word_count", word_count,      32'd251);

      // single flipped bit while locked
      do_reset();
      send_stream(16'h0001, 256, 0, 100);
      chk("single_pulses",     32'(pulses),    32'd1);
      chk("single_err_count",  32'(err_count), 32'd1);
      chk("single_locked",     32'(locked),    32'd1);
      chk("single_fall_idx",   32'(fall_idx),  32'hFFFF_FFFF);
      chk("single_word_count", word_count,     32'd251);

      // loss and relock on a fresh sequence
      do_reset();
      send_stream(16'h0001, 50, 0, -1);
      send_stream(16'h1234, 40, 0, -1);
      chk("loss_pulses",    32'(pulses),    32'd8);
      chk("loss_err_count", 32'(err_count), 32'd8);
      chk("loss_fall_idx",  32'(fall_idx),  32'd7);
      chk("relock_idx",     32'(rise_idx),  32'd12);

      // clear_counts coinciding with a locked mismatch
      do_reset();
      send_stream(16'h0001, 20, 0, -1);
      cycle(1'b1, m_exp ^ 16'h0010, 1'b1, 1'b0);
      chk("clr_err_count",  32'(err_count), 32'd0);
      chk("clr_word_count", word_count,     32'd0);
      chk("clr_err_pulse",  32'(err_pulse), 32'd1);
      chk("clr_locked",     32'(locked),    32'd1);

      // reset mid-lock
      do_reset();
      send_stream(16'h0001, 20, 0, 12);
      cycle(1'b1, m_exp, 1'b0, 1'b1);
      chk("midrst_locked",     32'(locked),    32'd0);
      chk("midrst_err_count",  32'(err_count), 32'd0);
      chk("midrst_word_count", word_count,     32'd0);
      chk("midrst_expected",   32'(expected),  32'd0);

      // randomized traffic: gaps, bit errors, zeros, garbage bursts, clears, resets
      do_reset();
      g = 16'($urandom_range(1, 65535));
      burst = 0;
      for (int c = 0; c < 3000; c++) begin
         int r;
         v   = ($urandom_range(99) < 80);
         clr = ($urandom_range(99) < 2);
         rst = ($urandom_range(999) == 0);
         w   = 16'($urandom);
         if (v) begin
            r = int'($urandom_range(999));
            if (burst > 0) begin
               burst--;
            end else if (r < 20) begin
               w = g ^ (16'h0001 << $urandom_range(15));
            end else if (r < 28) begin
               w = 16'h0000;
            end else if (r < 33) begin
               burst = int'($urandom_range(4, 14));
            end else begin
               w = g;
            end
            g = lfsr_next(g);
         end
         cycle(v, w, clr, rst);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
